// File: rtl/key_event_queue_if.sv
// Byte-input and event-output bundle for key_event_queue.
// master = decoder/FIFO side, slave = receiver/consumer side.
interface key_event_queue_if #(
  parameter int unsigned FIFO_DEPTH = 8
);
  logic [7:0]                    key_data_in;
  logic                          key_changed;
  logic                          ev_valid;
  logic                          ev_ready;
  logic [15:0]                   ev_code;
  logic                          ev_break;
  logic                          ev_repeat;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;
  logic                          overflow;
  logic                          overflow_clr;

  modport master (
    input  key_data_in, key_changed, ev_ready, overflow_clr,
    output ev_valid, ev_code, ev_break, ev_repeat, fifo_count, overflow
  );

  modport slave (
    output key_data_in, key_changed, ev_ready, overflow_clr,
    input  ev_valid, ev_code, ev_break, ev_repeat, fifo_count, overflow
  );
endinterface

// File: rtl/key_event_queue.sv
// PS/2 set-2 scan-code decoder with held-key tracking feeding an event FIFO.
// Events leave the decoder one cycle after the final byte strobe.
module key_event_queue #(
  parameter int unsigned FIFO_DEPTH    = 8,
  parameter bit          FILTER_REPEAT = 1'b0
) (
  input  logic               global_clk,
  input  logic               global_rst_n,
  key_event_queue_if.master  bus
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {IDLE, EXT, BRK, PAUSE} dec_state_e;

  dec_state_e   state_q;
  logic         ext_q;
  logic [2:0]   cnt_q;
  logic [511:0] held_q;
  logic         push_q;
  logic [17:0]  push_ent_q;

  logic [7:0]   byte_w;
  logic         mk_req;
  logic         brk_req;
  logic [8:0]   key_idx;
  logic [15:0]  key_code;

  assign byte_w   = bus.key_data_in;
  assign key_code = {(key_idx[8] ? 8'hE0 : 8'h00), key_idx[7:0]};

  always_comb begin
    mk_req  = 1'b0;
    brk_req = 1'b0;
    key_idx = {1'b0, byte_w};
    if (bus.key_changed) begin
      case (state_q)
        IDLE:  mk_req = !(byte_w inside {8'hE0, 8'hF0, 8'hE1, 8'hAA, 8'hFA,
                                         8'hEE, 8'hFE, 8'h00, 8'hFF});
        EXT: begin
          mk_req  = !(byte_w inside {8'hF0, 8'hE0, 8'hE1});
          key_idx = {1'b1, byte_w};
        end
        BRK: begin
          brk_req = 1'b1;
          key_idx = {ext_q, byte_w};
        end
        PAUSE: ;
      endcase
    end
  end

  always_ff @(posedge global_clk) begin
    if (!global_rst_n) begin
      state_q    <= IDLE;
      ext_q      <= 1'b0;
      cnt_q      <= '0;
      held_q     <= '0;
      push_q     <= 1'b0;
      push_ent_q <= '0;
    end else begin
      push_q <= 1'b0;
      if (mk_req) begin
        if (!held_q[key_idx]) begin
          held_q[key_idx] <= 1'b1;
          push_q          <= 1'b1;
          push_ent_q      <= {2'b00, key_code};
        end else if (!FILTER_REPEAT) begin
          push_q     <= 1'b1;
          push_ent_q <= {2'b01, key_code};
        end
      end
      if (brk_req) begin
        held_q[key_idx] <= 1'b0;
        push_q          <= 1'b1;
        push_ent_q      <= {2'b10, key_code};
      end
      if (bus.key_changed) begin
        case (state_q)
          IDLE: begin
            case (byte_w)
              8'hE0: state_q <= EXT;
              8'hF0: begin state_q <= BRK; ext_q <= 1'b0; end
              8'hE1: begin state_q <= PAUSE; cnt_q <= 3'd7; end
              8'hAA: held_q <= '0;
              default: ;
            endcase
          end
          EXT: begin
            if (byte_w == 8'hF0) begin
              state_q <= BRK;
              ext_q   <= 1'b1;
            end else begin
              state_q <= IDLE;
            end
          end
          BRK: state_q <= IDLE;
          PAUSE: begin
            cnt_q <= cnt_q - 3'd1;
            if (cnt_q == 3'd1) begin
              state_q    <= IDLE;
              push_q     <= 1'b1;
              push_ent_q <= {2'b00, 16'hE114};
            end
          end
        endcase
      end
    end
  end

  logic [17:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] count_q, count_d, after_pop;
  logic          valid_q, valid_d;
  logic [17:0]   head_q, head_d;
  logic          ovf_q, ovf_d;
  logic          pop, full, wr_en, drop;

  // Head is registered; when the FIFO drains to the entry being written,
  // that write data becomes the head directly.
  always_comb begin
    pop       = valid_q && bus.ev_ready;
    full      = (count_q == CW'(FIFO_DEPTH));
    wr_en     = push_q && (!full || pop);
    drop      = push_q && full && !pop;
    rd_d      = rd_q + AW'(pop);
    wr_d      = wr_q + AW'(wr_en);
    after_pop = count_q - CW'(pop);
    count_d   = after_pop + CW'(wr_en);
    valid_d   = (count_d != '0);
    head_d    = head_q;
    if (count_d != '0) head_d = (after_pop == '0) ? push_ent_q : mem_q[rd_d];
    ovf_d     = drop ? 1'b1 : (bus.overflow_clr ? 1'b0 : ovf_q);
  end

  always_ff @(posedge global_clk) begin
    if (wr_en) mem_q[wr_q] <= push_ent_q;
  end

  always_ff @(posedge global_clk) begin
    if (!global_rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      head_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      valid_q <= valid_d;
      head_q  <= head_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.ev_valid   = valid_q;
  assign bus.ev_break   = head_q[17];
  assign bus.ev_repeat  = head_q[16];
  assign bus.ev_code    = head_q[15:0];
  assign bus.fifo_count = count_q;
  assign bus.overflow   = ovf_q;
endmodule

// File: tb/tb_key_event_queue.sv
// Bench for key_event_queue: two instances (depth 4 keeping repeats, depth 8
// filtering them) against a byte-sequence / queue reference model.
module tb_key_event_queue;
  localparam int unsigned D0 = 4;
  localparam int unsigned D1 = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] kd = '0;
  logic kc = 1'b0;
  logic rdy = 1'b0;
  logic clr = 1'b0;
  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  key_event_queue_if #(.FIFO_DEPTH(D0)) bus0 ();
  key_event_queue_if #(.FIFO_DEPTH(D1)) bus1 ();

  assign bus0.key_data_in  = kd;
  assign bus0.key_changed  = kc;
  assign bus0.ev_ready     = rdy;
  assign bus0.overflow_clr = clr;
  assign bus1.key_data_in  = kd;
  assign bus1.key_changed  = kc;
  assign bus1.ev_ready     = rdy;
  assign bus1.overflow_clr = clr;

  key_event_queue #(.FIFO_DEPTH(D0), .FILTER_REPEAT(1'b0)) dut0 (
    .global_clk(clk), .global_rst_n(rst_n), .bus(bus0));
  key_event_queue #(.FIFO_DEPTH(D1), .FILTER_REPEAT(1'b1)) dut1 (
    .global_clk(clk), .global_rst_n(rst_n), .bus(bus1));

  // Reference model: pending prefix bytes, held-key set, event queue.
  logic [7:0]  mpend [2][$];
  bit          mheld [2][512];
  logic [17:0] mq    [2][$];
  logic [17:0] mlast [2];
  bit          movf  [2];
  bit          mhas  [2];
  logic [17:0] mev   [2];
  int unsigned mdepth [2] = '{D0, D1};
  bit          mfilt  [2] = '{1'b0, 1'b1};

  function automatic void emit(int i, logic [17:0] e);
    mhas[i] = 1'b1;
    mev[i]  = e;
  endfunction

  function automatic void key_event(int i, bit ext, logic [7:0] b, bit brk);
    int idx = (ext ? 256 : 0) + int'(b);
    logic [15:0] code = {(ext ? 8'hE0 : 8'h00), b};
    if (brk) begin
      mheld[i][idx] = 1'b0;
      emit(i, {2'b10, code});
    end else if (mheld[i][idx]) begin
      if (!mfilt[i]) emit(i, {2'b01, code});
    end else begin
      mheld[i][idx] = 1'b1;
      emit(i, {2'b00, code});
    end
  endfunction

  function automatic void model_byte(int i, logic [7:0] b);
    if (mpend[i].size() == 0) begin
      if (b inside {8'hE0, 8'hF0, 8'hE1}) mpend[i].push_back(b);
      else if (b == 8'hAA) begin
        for (int k = 0; k < 512; k++) mheld[i][k] = 1'b0;
      end else if (!(b inside {8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF}))
        key_event(i, 1'b0, b, 1'b0);
    end else if (mpend[i][0] == 8'hE1) begin
      mpend[i].push_back(b);
      if (mpend[i].size() == 8) begin
        emit(i, {2'b00, 16'hE114});
        mpend[i].delete();
      end
    end else if (mpend[i][mpend[i].size()-1] == 8'hF0) begin
      key_event(i, mpend[i][0] == 8'hE0, b, 1'b1);
      mpend[i].delete();
    end else begin
      if (b == 8'hF0) mpend[i].push_back(b);
      else begin
        mpend[i].delete();
        if (!(b inside {8'hE0, 8'hE1})) key_event(i, 1'b1, b, 1'b0);
      end
    end
  endfunction

  function automatic void model_edge(int i);
    bit pop, full, drop;
    if (!rst_n) begin
      mpend[i].delete();
      mq[i].delete();
      for (int k = 0; k < 512; k++) mheld[i][k] = 1'b0;
      mlast[i] = '0;
      movf[i]  = 1'b0;
      mhas[i]  = 1'b0;
      return;
    end
    pop  = (mq[i].size() != 0) && rdy;
    full = (mq[i].size() == mdepth[i]);
    drop = mhas[i] && full && !pop;
    if (pop) void'(mq[i].pop_front());
    if (mhas[i] && !drop) mq[i].push_back(mev[i]);
    if (drop) movf[i] = 1'b1;
    else if (clr) movf[i] = 1'b0;
    if (mq[i].size() != 0) mlast[i] = mq[i][0];
    mhas[i] = 1'b0;
    if (kc) model_byte(i, kd);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cmp_dut(input int i, input logic v, input logic [31:0] cnt,
                         input logic [17:0] head, input logic ovf);
    logic [17:0] eh = (mq[i].size() != 0) ? mq[i][0] : mlast[i];
    string p = (i == 0) ? "d0" : "d1";
    chk({p, ".ev_valid"}, 32'(v), 32'(mq[i].size() != 0));
    chk({p, ".fifo_count"}, cnt, 32'(mq[i].size()));
    chk({p, ".overflow"}, 32'(ovf), 32'(movf[i]));
    chk({p, ".ev_code"}, 32'(head[15:0]), 32'(eh[15:0]));
    chk({p, ".ev_break"}, 32'(head[17]), 32'(eh[17]));
    chk({p, ".ev_repeat"}, 32'(head[16]), 32'(eh[16]));
  endtask

  task automatic step(input logic c, input logic [7:0] d, input logic r, input logic cl);
    @(negedge clk);
    kc = c; kd = d; rdy = r; clr = cl;
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
    cmp_dut(0, bus0.ev_valid, 32'(bus0.fifo_count),
            {bus0.ev_break, bus0.ev_repeat, bus0.ev_code}, bus0.overflow);
    cmp_dut(1, bus1.ev_valid, 32'(bus1.fifo_count),
            {bus1.ev_break, bus1.ev_repeat, bus1.ev_code}, bus1.overflow);
  endtask

  task automatic send(input logic [7:0] d);
    step(1'b1, d, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic drain();
    for (int k = 0; k < 10; k++) step(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    rst_n = 1'b1;
  endtask

  logic [7:0] pool [13] = '{8'h1C, 8'h32, 8'hE0, 8'hF0, 8'hE1, 8'hAA, 8'hFA,
                            8'h75, 8'h14, 8'h77, 8'h5A, 8'hE0, 8'hF0};

  initial begin
    do_reset();
    chk("reset.code", 32'(bus0.ev_code), 32'h0);

    // Make then break with consumer stalled.
    step(1'b1, 8'h1C, 1'b0, 1'b0);
    chk("make.latency", 32'(bus0.ev_valid), 32'h0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("make.valid", 32'(bus0.ev_valid), 32'h1);
    send(8'hF0); send(8'h1C);
    chk("mkbrk.count", 32'(bus0.fifo_count), 32'd2);
    drain();

    send(8'hE0); send(8'h75);
    chk("ext.code", 32'(bus0.ev_code), 32'hE075);
    send(8'hE0); send(8'hF0); send(8'h75);
    drain();

    send(8'h1C); send(8'h1C); send(8'h1C);
    chk("rep.count0", 32'(bus0.fifo_count), 32'd3);
    chk("rep.count1", 32'(bus1.fifo_count), 32'd1);
    drain();
    send(8'hF0); send(8'h1C);
    drain();

    foreach (pool[k]) if (k < 0) send(pool[k]);
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    chk("pause.count", 32'(bus0.fifo_count), 32'd1);
    chk("pause.code", 32'(bus0.ev_code), 32'hE114);
    drain();

    send(8'h15); send(8'h1D); send(8'h24); send(8'h2D); send(8'h2C); send(8'h35);
    chk("ovf.count", 32'(bus0.fifo_count), 32'd4);
    chk("ovf.flag", 32'(bus0.overflow), 32'h1);
    chk("ovf.head", 32'(bus0.ev_code), 32'h0015);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("ovf.clr", 32'(bus0.overflow), 32'h0);
    step(1'b1, 8'h3C, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("full.pushpop.count", 32'(bus0.fifo_count), 32'd4);
    chk("full.pushpop.ovf", 32'(bus0.overflow), 32'h0);
    drain();

    send(8'hE0); send(8'hF0);
    do_reset();
    send(8'h1C);
    chk("rstmid.brk", 32'(bus0.ev_break), 32'h0);
    chk("rstmid.code", 32'(bus0.ev_code), 32'h001C);
    drain();

    send(8'h32); send(8'hAA); send(8'h32); send(8'hFA); send(8'hEE);
    drain();

    for (int n = 0; n < 700; n++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      step(1'b1, pool[$urandom_range(0, 12)], 1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 15) == 0));
      for (int g = 0; g < int'($urandom_range(1, 2)); g++)
        step(1'b0, 8'h00, 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 15) == 0));
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/key_event_queue.md
# key_event_queue

Parametrised PS/2 scan-code set 2 decoder with buffered event output, successor to the single-register break/extended decoder. It consumes the byte stream from the PS/2 receiver, collapses E0/F0/E1 prefix sequences into one event per key action, and tracks held keys to flag or drop typematic repeats. Decoded events go into a FIFO drained by the CPU-side keyboard peripheral through a valid/ready handshake.

## Interface
- FIFO_DEPTH, 8, event FIFO entries; power of two, minimum 2
- FILTER_REPEAT, 0, 1 = drop typematic repeat makes; 0 = enqueue them with ev_repeat=1
- global_clk  in  1  system clock; all logic rising-edge
- global_rst_n  in  1  reset, synchronous, active-low
- key_data_in  in  8  received scan-code byte, valid when key_changed=1
- key_changed  in  1  one-cycle byte strobe; strobes are at least 2 cycles apart
- ev_valid  out  1  FIFO head holds an event
- ev_ready  in  1  consumer accepts head this cycle
- ev_code  out  16  head key code: 0x00nn normal, 0xE0nn extended, 0xE114 Pause
- ev_break  out  1  head is a release
- ev_repeat  out  1  head is a make for a key already held
- fifo_count  out  $clog2(FIFO_DEPTH)+1  entries stored
- overflow  out  1  sticky: an event was dropped because the FIFO was full
- overflow_clr  in  1  clears overflow; a drop in the same cycle wins

## Operation
- Decoder states: IDLE, EXT (after E0), BRK (after F0; ext flag held), PAUSE (E1 sequence, 3-bit down-counter).
- IDLE: E0 -> EXT; F0 -> BRK with ext=0; E1 -> PAUSE with count=7; 0xAA (BAT pass) -> clear held bitmap and discard; FA, EE, FE, 00, FF -> discard; any other byte -> make event {0x00, byte}.
- EXT: F0 -> BRK with ext=1; E0/E1 -> discard and go to IDLE (protocol error); other byte -> make {0xE0, byte}, go to IDLE.
- BRK: any byte -> break event {ext?0xE0:0x00, byte}, go to IDLE.
- PAUSE: each strobe decrements count; the strobe that brings it to 0 emits make 0xE114 (ev_break=0, ev_repeat=0) and returns to IDLE. Byte values inside PAUSE are ignored.
- Held bitmap: 512 bits indexed {ext, code[7:0]}. A make with bit clear sets it and enqueues ev_repeat=0. A make with bit set enqueues ev_repeat=1, or is dropped when FILTER_REPEAT=1. A break clears the bit and is always enqueued. Pause is not tracked.
- FIFO entry is 18 bits {ev_break, ev_repeat, ev_code}. Head outputs are valid only while ev_valid=1; otherwise they hold their last value.
- Push while full with no pop: event dropped, overflow set, contents unchanged. Push and pop in the same cycle while full: both occur, count unchanged, no overflow. Push and pop on an empty FIFO: push only, since ev_valid was 0.
- overflow_clr and a drop in the same cycle: overflow stays 1.

## Timing
- Reset (global_rst_n=0 at an edge) clears: decoder to IDLE, PAUSE counter, held bitmap, FIFO pointers, fifo_count=0, ev_valid=0, ev_code=0, ev_break=0, ev_repeat=0, overflow=0. Reset mid-sequence abandons it; no partial event is emitted.
- Latency: the final byte's strobe is sampled at edge k; the entry is written at edge k+1; ev_valid=1 and fifo_count are updated after edge k+1.
- Pop occurs at an edge where ev_valid and ev_ready are both 1. The next head, or ev_valid=0, is visible after that edge. Holding ev_ready=1 gives one pop per cycle.
- Prefix bytes (E0, F0, and E1 sequence bytes other than the last) and discarded bytes produce no FIFO activity.
- Pointers wrap modulo FIFO_DEPTH. fifo_count ranges 0..FIFO_DEPTH.

## Test plan
- Bytes 1C, F0 1C with ev_ready=0 -> two entries: {0x001C, brk0, rep0} then {0x001C, brk1, rep0}; fifo_count=2; ev_valid rises 1 cycle after the 1C strobe.
- Bytes E0 75, E0 F0 75 -> {0xE075, brk0} then {0xE075, brk1}; bitmap bit {1,0x75} set, then cleared.
- FILTER_REPEAT=0, bytes 1C 1C 1C -> three entries with ev_repeat 0,1,1. FILTER_REPEAT=1, same bytes -> one entry.
- Bytes E1 14 77 E1 F0 14 F0 77 -> exactly one entry {0xE114, brk0, rep0}; decoder back in IDLE.
- FIFO_DEPTH=4, ev_ready=0, six distinct makes -> count=4, overflow=1, head = first make. Pulse overflow_clr -> overflow=0. Push coinciding with a pop when full -> no overflow.
- Assert global_rst_n=0 after E0 F0 -> next byte 1C yields {0x001C, brk0}. Byte AA after makes -> bitmap cleared, the next make has rep0; FA/EE produce no entries.
